// File: rtl/conv_fifo_pkg.sv
// conv_fifo_pkg: shared defaults and sizing helpers for the FIFO read-side unpacker.
//   RD_DATA_WIDTH_DEF : default FIFO read word width
//   OUT_WIDTH_DEF     : default output sample width
//   LINE_LEN_DEF      : default samples per line
//   lane_count()      : output lanes per read word
//   cnt_width()       : counter width able to index 0..n-1 (at least 1 bit)
package conv_fifo_pkg;

    localparam int unsigned RD_DATA_WIDTH_DEF = 64;
    localparam int unsigned OUT_WIDTH_DEF     = 16;
    localparam int unsigned LINE_LEN_DEF      = 224;

    function automatic int unsigned lane_count(input int unsigned rd_w, input int unsigned out_w);
        return rd_w / out_w;
    endfunction

    function automatic int unsigned cnt_width(input int unsigned n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/word_skid_buf.sv
// word_skid_buf: 2-entry word buffer between the FIFO read port and the lane selector.
//   clk, rst         : clock, asynchronous active-high reset
//   push, push_data  : write one word (caller never pushes into a full buffer)
//   pop              : free the head word (caller never pops an empty buffer)
//   head_data        : oldest buffered word
//   occupancy        : number of buffered words (0..2)
// A push and a pop in the same cycle both take effect and leave occupancy unchanged.
module word_skid_buf #(
    parameter int unsigned WIDTH = 64
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             push,
    input  logic [WIDTH-1:0] push_data,
    input  logic             pop,
    output logic [WIDTH-1:0] head_data,
    output logic [1:0]       occupancy
);

    logic [WIDTH-1:0] mem_q [2];
    logic [WIDTH-1:0] mem_d [2];
    logic             wr_ptr_q, wr_ptr_d;
    logic             rd_ptr_q, rd_ptr_d;
    logic [1:0]       cnt_q, cnt_d;

    always_comb begin
        mem_d    = mem_q;
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        cnt_d    = cnt_q;
        if (push) begin
            mem_d[wr_ptr_q] = push_data;
            wr_ptr_d        = ~wr_ptr_q;
        end
        if (pop) begin
            rd_ptr_d = ~rd_ptr_q;
        end
        case ({push, pop})
            2'b10:   cnt_d = cnt_q + 2'd1;
            2'b01:   cnt_d = cnt_q - 2'd1;
            default: cnt_d = cnt_q;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            mem_q[0] <= '0;
            mem_q[1] <= '0;
            wr_ptr_q <= 1'b0;
            rd_ptr_q <= 1'b0;
            cnt_q    <= 2'd0;
        end else begin
            mem_q    <= mem_d;
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            cnt_q    <= cnt_d;
        end
    end

    assign head_data = mem_q[rd_ptr_q];
    assign occupancy = cnt_q;

endmodule

// File: rtl/fifo_rd_unpack.sv
// fifo_rd_unpack: pops wide words from an async FIFO read port and emits them as a
// ready/valid stream of narrower samples, with an end-of-line marker.
//   rd_clk, rd_rst               : clock, asynchronous active-high reset
//   fifo_rd_en                   : pop request (combinational)
//   fifo_rd_empty, fifo_rd_data  : FIFO status and read data (data valid one cycle after pop)
//   m_valid, m_ready, m_data     : registered output sample stream
//   m_eol                        : marks the last sample of each LINE_LEN-sample line
// Build option: define UNPACK_MSB_FIRST_EN to emit the most significant lane first;
// otherwise lane 0 is the least significant OUT_WIDTH bits.
import conv_fifo_pkg::*;

module fifo_rd_unpack #(
    parameter int unsigned RD_DATA_WIDTH = RD_DATA_WIDTH_DEF,
    parameter int unsigned OUT_WIDTH     = OUT_WIDTH_DEF,
    parameter int unsigned LINE_LEN      = LINE_LEN_DEF
) (
    input  logic                     rd_clk,
    input  logic                     rd_rst,
    output logic                     fifo_rd_en,
    input  logic                     fifo_rd_empty,
    input  logic [RD_DATA_WIDTH-1:0] fifo_rd_data,
    output logic                     m_valid,
    input  logic                     m_ready,
    output logic [OUT_WIDTH-1:0]     m_data,
    output logic                     m_eol
);

    localparam int unsigned LANES  = lane_count(RD_DATA_WIDTH, OUT_WIDTH);
    localparam int unsigned LANE_W = cnt_width(LANES);
    localparam int unsigned LINE_W = cnt_width(LINE_LEN);
    localparam logic [LANE_W-1:0] LAST_LANE = LANE_W'(LANES - 1);
    localparam logic [LINE_W-1:0] LAST_IDX  = LINE_W'(LINE_LEN - 1);

    logic                     in_flight_q, in_flight_d;
    logic [LANE_W-1:0]        lane_q, lane_d;
    logic [LINE_W-1:0]        line_q, line_d;
    logic                     m_valid_q, m_valid_d;
    logic [OUT_WIDTH-1:0]     m_data_q, m_data_d;
    logic                     m_eol_q, m_eol_d;

    logic [1:0]               occ;
    logic [RD_DATA_WIDTH-1:0] head;
    logic                     load;
    logic                     buf_pop;
    logic [OUT_WIDTH-1:0]     lane_data;

    // Gated by reset so no pop is issued while flops are held cleared.
    assign fifo_rd_en  = !rd_rst && !fifo_rd_empty
                         && (({1'b0, occ} + {2'b00, in_flight_q}) < 3'd2);
    assign in_flight_d = fifo_rd_en;

    // Output register takes the next lane whenever it is empty or being drained.
    assign load    = (occ != 2'd0) && (!m_valid_q || m_ready);
    assign buf_pop = load && (lane_q == LAST_LANE);

    word_skid_buf #(
        .WIDTH(RD_DATA_WIDTH)
    ) u_buf (
        .clk       (rd_clk),
        .rst       (rd_rst),
        .push      (in_flight_q),
        .push_data (fifo_rd_data),
        .pop       (buf_pop),
        .head_data (head),
        .occupancy (occ)
    );

    always_comb begin
        lane_data = '0;
        for (int i = 0; i < int'(LANES); i++) begin
            if (lane_q == LANE_W'(i)) begin
`ifdef UNPACK_MSB_FIRST_EN
                lane_data = head[RD_DATA_WIDTH - 1 - i * OUT_WIDTH -: OUT_WIDTH];
`else
                lane_data = head[i * OUT_WIDTH +: OUT_WIDTH];
`endif
            end
        end
    end

    // line_q indexes the sample about to enter the output register; every loaded
    // sample is later transferred, so this tracks transfers one stage early and lets
    // m_eol be registered alongside m_data.
    always_comb begin
        m_valid_d = m_valid_q;
        m_data_d  = m_data_q;
        m_eol_d   = m_eol_q;
        lane_d    = lane_q;
        line_d    = line_q;
        if (load) begin
            m_valid_d = 1'b1;
            m_data_d  = lane_data;
            m_eol_d   = (line_q == LAST_IDX);
            lane_d    = (lane_q == LAST_LANE) ? '0 : lane_q + 1'b1;
            line_d    = (line_q == LAST_IDX) ? '0 : line_q + 1'b1;
        end else if (m_ready) begin
            m_valid_d = 1'b0;
        end
    end

    always_ff @(posedge rd_clk or posedge rd_rst) begin
        if (rd_rst) begin
            in_flight_q <= 1'b0;
            lane_q      <= '0;
            line_q      <= '0;
            m_valid_q   <= 1'b0;
            m_data_q    <= '0;
            m_eol_q     <= 1'b0;
        end else begin
            in_flight_q <= in_flight_d;
            lane_q      <= lane_d;
            line_q      <= line_d;
            m_valid_q   <= m_valid_d;
            m_data_q    <= m_data_d;
            m_eol_q     <= m_eol_d;
        end
    end

    assign m_valid = m_valid_q;
    assign m_data  = m_data_q;
    assign m_eol   = m_eol_q;

endmodule

// File: tb/tb_fifo_rd_unpack.sv
// Bench for fifo_rd_unpack: FIFO model, scoreboarded output stream, table-driven single
// word vectors and hand-written sequences for back-to-back, stall, gap, reset and line
// corner cases. Built with LINE_LEN = 6.
module tb_fifo_rd_unpack;

    localparam int unsigned RDW = 64;
    localparam int unsigned OW  = 16;
    localparam int unsigned LL  = 6;

    logic            rd_clk = 1'b0;
    logic            rd_rst = 1'b1;
    logic            fifo_rd_en;
    logic            fifo_rd_empty;
    logic [RDW-1:0]  fifo_rd_data = '0;
    logic            m_valid;
    logic            m_ready = 1'b1;
    logic [OW-1:0]   m_data;
    logic            m_eol;

    always #5 rd_clk = ~rd_clk;

    fifo_rd_unpack #(
        .RD_DATA_WIDTH(RDW),
        .OUT_WIDTH    (OW),
        .LINE_LEN     (LL)
    ) dut (
        .rd_clk       (rd_clk),
        .rd_rst       (rd_rst),
        .fifo_rd_en   (fifo_rd_en),
        .fifo_rd_empty(fifo_rd_empty),
        .fifo_rd_data (fifo_rd_data),
        .m_valid      (m_valid),
        .m_ready      (m_ready),
        .m_data       (m_data),
        .m_eol        (m_eol)
    );

    int n_chk  = 0;
    int n_pass = 0;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_chk++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
    endtask

    // Upstream FIFO model: read data appears one cycle after a pop.
    logic [RDW-1:0] mem [512];
    logic [9:0]     wr_idx = '0;
    logic [9:0]     rd_idx = '0;
    int             pop_err = 0;

    assign fifo_rd_empty = (wr_idx == rd_idx);

    always @(posedge rd_clk) begin
        if (fifo_rd_en) begin
            if (fifo_rd_empty) pop_err <= pop_err + 1;
            else begin
                fifo_rd_data <= mem[rd_idx[8:0]];
                rd_idx       <= rd_idx + 10'd1;
            end
        end
    end

    typedef struct packed {
        logic [OW-1:0] data;
        logic          eol;
    } exp_t;

    exp_t exp_q[$];
    int   exp_line = 0;

    function automatic logic [OW-1:0] lane_of(input logic [RDW-1:0] w, input int i);
`ifdef UNPACK_MSB_FIRST_EN
        lane_of = w[RDW - 1 - OW * i -: OW];
`else
        lane_of = w[OW * i +: OW];
`endif
    endfunction

    task automatic fifo_put(input logic [RDW-1:0] w);
        mem[wr_idx[8:0]] = w;
        wr_idx = wr_idx + 10'd1;
    endtask

    task automatic exp_put(input logic [RDW-1:0] w);
        for (int i = 0; i < 4; i++) begin
            exp_q.push_back('{data: lane_of(w, i), eol: (exp_line == int'(LL) - 1)});
            exp_line = (exp_line == int'(LL) - 1) ? 0 : exp_line + 1;
        end
    endtask

    task automatic push_word(input logic [RDW-1:0] w);
        fifo_put(w);
        exp_put(w);
    endtask

    // Output monitor: drives m_ready for the coming edge, then scores the transfer.
    int            ready_mode = 0;  // 0: always ready, 1: random, 2: never ready
    int            n_xfer = 0;
    logic          stall_q = 1'b0;
    logic [OW-1:0] stall_data = '0;
    logic          stall_eol = 1'b0;

    always @(negedge rd_clk) begin
        exp_t e;
        case (ready_mode)
            0:       m_ready = 1'b1;
            1:       m_ready = 1'($urandom_range(0, 1));
            default: m_ready = 1'b0;
        endcase
        if (rd_rst) begin
            stall_q = 1'b0;
        end else begin
            if (stall_q) begin
                chk("hold_valid", 64'(m_valid), 64'd1);
                chk("hold_data", 64'(m_data), 64'(stall_data));
                chk("hold_eol", 64'(m_eol), 64'(stall_eol));
            end
            if (m_valid && m_ready) begin
                n_xfer++;
                if (exp_q.size() == 0) begin
                    chk("extra_sample", 64'(m_data), 64'hDEAD_0000_0000_0000);
                end else begin
                    e = exp_q.pop_front();
                    chk("stream_data", 64'(m_data), 64'(e.data));
                    chk("stream_eol", 64'(m_eol), 64'(e.eol));
                end
            end
            stall_q    = m_valid && !m_ready;
            stall_data = m_data;
            stall_eol  = m_eol;
        end
    end

    task automatic wait_drain(input int budget, input string name);
        int k = 0;
        while (exp_q.size() != 0 && k < budget) begin
            @(negedge rd_clk);
            k++;
        end
        chk(name, 64'(exp_q.size()), 64'd0);
        repeat (3) @(negedge rd_clk);
    endtask

    typedef struct {
        logic [RDW-1:0]    word;
        logic [3:0][OW-1:0] lanes;  // LSB-first lane order; lanes[0] is lane 0
    } vec_t;

    vec_t tbl [3];

    initial begin
        int             k;
        int             x0;
        int             bubbles;
        int             n;
        logic [11:0]    eol_vec;
        logic [RDW-1:0] wa, wb, wc;
        int             li;

        tbl[0] = '{word: 64'h0123_4567_89AB_CDEF, lanes: {16'h0123, 16'h4567, 16'h89AB, 16'hCDEF}};
        tbl[1] = '{word: 64'hFFFF_0000_AAAA_5555, lanes: {16'hFFFF, 16'h0000, 16'hAAAA, 16'h5555}};
        tbl[2] = '{word: 64'h8000_0001_0002_0003, lanes: {16'h8000, 16'h0001, 16'h0002, 16'h0003}};

        // Reset state, with a word waiting in the FIFO.
        @(negedge rd_clk);
        push_word(64'h1111_2222_3333_4444);
        repeat (2) begin
            @(negedge rd_clk);
            chk("rst_rd_en", 64'(fifo_rd_en), 64'd0);
            chk("rst_valid", 64'(m_valid), 64'd0);
            chk("rst_data", 64'(m_data), 64'd0);
            chk("rst_eol", 64'(m_eol), 64'd0);
        end
        rd_rst = 1'b0;
        wait_drain(30, "drain_first");

        // Single-word vectors: exact latency and lane order.
        for (int v = 0; v < 3; v++) begin
            @(negedge rd_clk);
            push_word(tbl[v].word);
            repeat (2) @(negedge rd_clk);
            chk("vec_latency", 64'(m_valid), 64'd0);
            for (int i = 0; i < 4; i++) begin
                @(negedge rd_clk);
`ifdef UNPACK_MSB_FIRST_EN
                li = 3 - i;
`else
                li = i;
`endif
                chk("vec_valid", 64'(m_valid), 64'd1);
                chk("vec_data", 64'(m_data), 64'(tbl[v].lanes[li]));
            end
            @(negedge rd_clk);
            chk("vec_idle", 64'(m_valid), 64'd0);
            wait_drain(10, "vec_drain");
        end

        // Back-to-back: 64 words, ready held high, no bubbles.
        ready_mode = 0;
        x0 = n_xfer;
        for (int w = 0; w < 64; w++) push_word({$urandom, $urandom});
        k = 0;
        while (!m_valid && k < 20) begin
            @(negedge rd_clk);
            k++;
        end
        chk("b2b_start", 64'(m_valid), 64'd1);
        bubbles = 0;
        for (int i = 1; i < 256; i++) begin
            @(negedge rd_clk);
            if (!m_valid) bubbles++;
        end
        chk("b2b_bubbles", 64'(bubbles), 64'd0);
        wait_drain(50, "b2b_drain");
        chk("b2b_count", 64'(n_xfer - x0), 64'd256);

        // Random backpressure: stream compared against the scoreboard.
        ready_mode = 1;
        x0 = n_xfer;
        for (int w = 0; w < 64; w++) push_word({$urandom, $urandom});
        wait_drain(3000, "rand_drain");
        chk("rand_count", 64'(n_xfer - x0), 64'd256);
        ready_mode = 0;
        repeat (3) @(negedge rd_clk);

        // FIFO runs dry for 10 cycles mid-stream.
        push_word(64'hA1A2_A3A4_A5A6_A7A8);
        wait_drain(30, "gap_drain1");
        bubbles = 0;
        repeat (10) begin
            @(negedge rd_clk);
            if (m_valid) bubbles++;
        end
        chk("gap_valid_low", 64'(bubbles), 64'd0);
        push_word(64'hB1B2_B3B4_B5B6_B7B8);
        wait_drain(30, "gap_drain2");

        // Reset with two words buffered and one still in the FIFO.
        ready_mode = 2;
        wa = 64'hAAAA_0003_0002_0001;
        wb = 64'hBBBB_0003_0002_0001;
        wc = 64'hCCCC_0007_0006_0005;
        @(negedge rd_clk);
        fifo_put(wa);
        fifo_put(wb);
        fifo_put(wc);
        repeat (8) @(negedge rd_clk);
        chk("pre_rst_valid", 64'(m_valid), 64'd1);
        chk("pre_rst_data", 64'(m_data), 64'(lane_of(wa, 0)));
        rd_rst = 1'b1;
        repeat (2) begin
            @(negedge rd_clk);
            chk("mid_rst_rd_en", 64'(fifo_rd_en), 64'd0);
            chk("mid_rst_valid", 64'(m_valid), 64'd0);
            chk("mid_rst_data", 64'(m_data), 64'd0);
            chk("mid_rst_eol", 64'(m_eol), 64'd0);
        end
        rd_rst = 1'b0;
        exp_line = 0;
        exp_put(wc);
        ready_mode = 0;
        k = 0;
        while (!m_valid && k < 20) begin
            @(negedge rd_clk);
            k++;
        end
        chk("post_rst_data", 64'(m_data), 64'(lane_of(wc, 0)));
        wait_drain(30, "post_rst_drain");

        // Line boundaries across words: LINE_LEN 6 over 3 words.
        rd_rst = 1'b1;
        @(negedge rd_clk);
        rd_rst = 1'b0;
        exp_line = 0;
        for (int w = 0; w < 3; w++) push_word({32'h5A5A_0000 + 32'(w), $urandom});
        n = 0;
        eol_vec = '0;
        k = 0;
        while (n < 12 && k < 40) begin
            @(negedge rd_clk);
            if (m_valid && m_ready) begin
                eol_vec[n] = m_eol;
                n++;
            end
            k++;
        end
        chk("line_samples", 64'(n), 64'd12);
        chk("line_eol_map", 64'(eol_vec), 64'h820);
        wait_drain(20, "line_drain");

        chk("no_pop_on_empty", 64'(pop_err), 64'd0);
        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
